rf_wb_arbiter: RTL and testbench

- Shares the single RegisterFile write port (en / readRd / data_in) between two writeback sources: the ALU result path and the load unit.
- Round-robin arbitration with a one-cycle registered output stage.
- Keeps a pending-load scoreboard and reports read-after-load hazards to the decode stall logic.

---
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the RegisterFile write port.
// Round-robin ALU/load arbitration, pending-load scoreboard, hazard detect.
module rf_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic            issue_ld,
   input  logic [AW-1:0]   issue_rd,
   input  logic [AW-1:0]   chk_rs1,
   input  logic [AW-1:0]   chk_rs2,
   output logic            hazard,
   output logic            rf_en,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_data,
   output logic [NREG-1:0] pending
);

   logic            prio_q, prio_d;
   logic            en_q, en_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic            alu_hs, ld_hs;
   logic            hz1, hz2;

   // Grant: prio picks the winner on conflict; nothing is granted in reset
   always_comb begin
      alu_ready = !rst && !(ld_valid && prio_q);
      ld_ready  = !rst && !(alu_valid && !prio_q);
      alu_hs    = alu_valid && alu_ready;
      ld_hs     = ld_valid && ld_ready;
   end

   // Next state: priority flip on conflict, output capture, scoreboard
   always_comb begin
      prio_d = prio_q;
      en_d   = 1'b0;
      rd_d   = rd_q;
      data_d = data_q;
      pend_d = pend_q;
      if (alu_valid && ld_valid) begin
         prio_d = ~prio_q;
      end
      if (alu_hs) begin
         en_d   = (alu_rd != '0);
         rd_d   = alu_rd;
         data_d = alu_data;
      end else if (ld_hs) begin
         en_d   = (ld_rd != '0);
         rd_d   = ld_rd;
         data_d = ld_data;
      end
      if (ld_hs) begin
         pend_d[ld_rd] = 1'b0;
      end
      if (issue_ld && (issue_rd != '0)) begin
         pend_d[issue_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
         en_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         pend_q <= '0;
      end else begin
         prio_q <= prio_d;
         en_q   <= en_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         pend_q <= pend_d;
      end
   end

   // Read-after-load hazard: outstanding load or write landing this cycle
   always_comb begin
      hz1 = (chk_rs1 != '0) &&
            (pend_q[chk_rs1] || (en_q && (rd_q == chk_rs1)));
      hz2 = (chk_rs2 != '0) &&
            (pend_q[chk_rs2] || (en_q && (rd_q == chk_rs2)));
      hazard = hz1 || hz2;
   end

   assign rf_en   = en_q;
   assign rf_rd   = rd_q;
   assign rf_data = data_q;
   assign pending = pend_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter.
// Inputs change 1ns after the rising edge; outputs sampled after that.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        issue_ld;
   logic [4:0]  issue_rd;
   logic [4:0]  chk_rs1, chk_rs2;
   logic        hazard;
   logic        rf_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic [31:0] pending;

   int checks = 0;
   int errors = 0;

   rf_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_rd(ld_rd), .ld_data(ld_data),
      .issue_ld(issue_ld), .issue_rd(issue_rd),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
      .hazard(hazard),
      .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
      issue_ld = 0; issue_rd = 0;
      chk_rs1 = 0; chk_rs2 = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      alu_valid = 1; ld_valid = 1;
      cyc();
      cyc();
      checks++;
      if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
         $display("FAIL rst_ready got %b%b exp 00", alu_ready, ld_ready);
         errors++;
      end
      checks++;
      if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'h0) begin
         $display("FAIL rst_out got %b %0d %h exp 0 0 0", rf_en, rf_rd, rf_data);
         errors++;
      end
      checks++;
      if (pending !== 32'h0) begin
         $display("FAIL rst_pending got %h exp 0", pending);
         errors++;
      end
      rst = 0;
      idle();
      cyc();
   endtask

   task automatic test_alu_single();
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         $display("FAIL alu_ready got %b exp 1", alu_ready);
         errors++;
      end
      cyc();
      alu_valid = 0;
      checks++;
      if (rf_en !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
         $display("FAIL alu_wb got %b %0d %h exp 1 5 deadbeef", rf_en, rf_rd, rf_data);
         errors++;
      end
      cyc();
      checks++;
      if (rf_en !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
         $display("FAIL alu_hold got %b %0d %h exp 0 5 deadbeef", rf_en, rf_rd, rf_data);
         errors++;
      end
   endtask

   task automatic test_conflict();
      logic         a;
      logic [4:0]   erd;
      logic [31:0]  edat;
      alu_valid = 1; alu_rd = 3; alu_data = 32'hAAAA0003;
      ld_valid = 1; ld_rd = 7; ld_data = 32'hBBBB0007;
      for (int i = 0; i < 4; i++) begin
         a = (i % 2 == 0);
         erd = a ? 5'd3 : 5'd7;
         edat = a ? 32'hAAAA0003 : 32'hBBBB0007;
         #1;
         checks++;
         if (alu_ready !== a || ld_ready !== !a) begin
            $display("FAIL rr_grant%0d got %b%b exp %b%b", i,
                     alu_ready, ld_ready, a, !a);
            errors++;
         end
         cyc();
         checks++;
         if (rf_en !== 1'b1 || rf_rd !== erd || rf_data !== edat) begin
            $display("FAIL rr_out%0d got %b %0d %h exp 1 %0d %h", i,
                     rf_en, rf_rd, rf_data, erd, edat);
            errors++;
         end
      end
      idle();
      cyc();
   endtask

   task automatic test_hazard();
      issue_ld = 1; issue_rd = 9;
      cyc();
      issue_ld = 0;
      checks++;
      if (pending !== 32'h0000_0200) begin
         $display("FAIL hz_pend_set got %h exp 00000200", pending);
         errors++;
      end
      chk_rs1 = 9;
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         $display("FAIL hz_rs1 got %b exp 1", hazard);
         errors++;
      end
      chk_rs1 = 0; chk_rs2 = 9;
      #1;
      checks++;
      if (hazard !== 1'b1) begin
         $display("FAIL hz_rs2 got %b exp 1", hazard);
         errors++;
      end
      chk_rs1 = 9; chk_rs2 = 0;
      ld_valid = 1; ld_rd = 9; ld_data = 32'h0000_0055;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         $display("FAIL hz_ld_ready got %b exp 1", ld_ready);
         errors++;
      end
      cyc();
      ld_valid = 0;
      #1;
      checks++;
      if (pending[9] !== 1'b0) begin
         $display("FAIL hz_pend_clr got %b exp 0", pending[9]);
         errors++;
      end
      checks++;
      if (hazard !== 1'b1 || rf_en !== 1'b1 || rf_data !== 32'h55) begin
         $display("FAIL hz_inflight got %b %b %h exp 1 1 55", hazard, rf_en, rf_data);
         errors++;
      end
      cyc();
      checks++;
      if (hazard !== 1'b0) begin
         $display("FAIL hz_drop got %b exp 0", hazard);
         errors++;
      end
      idle();
   endtask

   task automatic test_set_wins();
      issue_ld = 1; issue_rd = 4;
      cyc();
      ld_valid = 1; ld_rd = 4; ld_data = 32'h44;
      cyc();
      issue_ld = 0; ld_valid = 0;
      checks++;
      if (pending !== 32'h0000_0010) begin
         $display("FAIL set_wins got %h exp 00000010", pending);
         errors++;
      end
      ld_valid = 1; ld_rd = 4;
      cyc();
      ld_valid = 0;
      checks++;
      if (pending !== 32'h0) begin
         $display("FAIL ld_clear got %h exp 0", pending);
         errors++;
      end
      issue_ld = 1; issue_rd = 0;
      cyc();
      issue_ld = 0;
      checks++;
      if (pending !== 32'h0) begin
         $display("FAIL issue_x0 got %h exp 0", pending);
         errors++;
      end
      idle();
   endtask

   task automatic test_x0_write();
      alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         $display("FAIL x0_ready got %b exp 1", alu_ready);
         errors++;
      end
      cyc();
      alu_valid = 0;
      checks++;
      if (rf_en !== 1'b0) begin
         $display("FAIL x0_en got %b exp 0", rf_en);
         errors++;
      end
      checks++;
      if (hazard !== 1'b0) begin
         $display("FAIL x0_hazard got %b exp 0", hazard);
         errors++;
      end
      idle();
      cyc();
   endtask

   task automatic test_reset_mid();
      issue_ld = 1; issue_rd = 12;
      cyc();
      issue_rd = 13;
      cyc();
      issue_ld = 0;
      checks++;
      if (pending !== 32'h0000_3000) begin
         $display("FAIL mid_pend got %h exp 00003000", pending);
         errors++;
      end
      alu_valid = 1; alu_rd = 6; alu_data = 32'h66;
      ld_valid = 1; ld_rd = 8; ld_data = 32'h88;
      cyc();
      rst = 1;
      #1;
      checks++;
      if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
         $display("FAIL mid_rst_ready got %b%b exp 00", alu_ready, ld_ready);
         errors++;
      end
      cyc();
      rst = 0;
      checks++;
      if (rf_en !== 1'b0 || pending !== 32'h0) begin
         $display("FAIL mid_rst_state got %b %h exp 0 0", rf_en, pending);
         errors++;
      end
      #1;
      checks++;
      if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
         $display("FAIL mid_prio got %b%b exp 10", alu_ready, ld_ready);
         errors++;
      end
      cyc();
      idle();
      checks++;
      if (rf_en !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 32'h66) begin
         $display("FAIL mid_first got %b %0d %h exp 1 6 66", rf_en, rf_rd, rf_data);
         errors++;
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_alu_single();
      test_conflict();
      test_hazard();
      test_set_wins();
      test_x0_write();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Arbitration must never accept two writebacks in one cycle
   always @(negedge clk) begin
      if (alu_valid && alu_ready && ld_valid && ld_ready) begin
         $display("FAIL dual_grant got 11 exp one");
         errors++;
      end
   end

endmodule
